// File: rtl/collision_damage_gen_if.sv
// Handshake bundle between the main FSM / enemy table and the collision damage generator.
// The slave side is the damage generator; the master side is the main FSM plus enemy table.
interface collision_damage_gen_if #(
    parameter int NUM_ENEMIES = 8,
    parameter int X_W         = 8,
    parameter int Y_W         = 7
);
    localparam int SEL_W = $clog2(NUM_ENEMIES);

    logic             startScan;
    logic [X_W-1:0]   playerX;
    logic [Y_W-1:0]   playerY;
    logic [SEL_W-1:0] enemySel;
    logic [X_W-1:0]   enemyX;
    logic [Y_W-1:0]   enemyY;
    logic             enemyValid;
    logic             inUpdatePositionStateMain;
    logic             inGameOverState;
    logic             updateHealth;
    logic             enemyKill;
    logic [SEL_W-1:0] killIdx;
    logic             scanDone;
    logic             invulnerable;

    modport slave (
        input  startScan, playerX, playerY, enemyX, enemyY, enemyValid,
               inUpdatePositionStateMain, inGameOverState,
        output enemySel, updateHealth, enemyKill, killIdx, scanDone, invulnerable
    );

    modport master (
        output startScan, playerX, playerY, enemyX, enemyY, enemyValid,
               inUpdatePositionStateMain, inGameOverState,
        input  enemySel, updateHealth, enemyKill, killIdx, scanDone, invulnerable
    );
endinterface

// File: rtl/collision_damage_gen.sv
// Per-frame enemy/player bounding-box scan issuing kill strobes and at most one
// health-damage pulse per frame, followed by a frame-counted invulnerability window.
module collision_damage_gen #(
    parameter int NUM_ENEMIES   = 8,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int PLAYER_SIZE   = 8,
    parameter int ENEMY_SIZE    = 4,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    collision_damage_gen_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_ENEMIES);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_ENEMIES - 1);
    localparam logic [X_W:0]     PSZ_X     = (X_W + 1)'(PLAYER_SIZE);
    localparam logic [X_W:0]     ESZ_X     = (X_W + 1)'(ENEMY_SIZE);
    localparam logic [Y_W:0]     PSZ_Y     = (Y_W + 1)'(PLAYER_SIZE);
    localparam logic [Y_W:0]     ESZ_Y     = (Y_W + 1)'(ENEMY_SIZE);
    localparam logic [7:0]       INV_LOAD  = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE, PENDING} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [SEL_W-1:0] r_sel;
    logic             r_hit;
    logic [7:0]       r_inv_cnt;

    logic [X_W:0] w_ex, w_px;
    logic [Y_W:0] w_ey, w_py;
    logic         w_overlap;
    logic         w_hit_slot;
    logic         w_invuln;

    // One extra bit on every sum so boxes near the coordinate maximum never wrap.
    assign w_ex = {1'b0, bus.enemyX};
    assign w_px = {1'b0, bus.playerX};
    assign w_ey = {1'b0, bus.enemyY};
    assign w_py = {1'b0, bus.playerY};

    assign w_overlap = (w_ex < (w_px + PSZ_X)) && (w_px < (w_ex + ESZ_X)) &&
                       (w_ey < (w_py + PSZ_Y)) && (w_py < (w_ey + ESZ_Y));
    assign w_hit_slot = bus.enemyValid && w_overlap;
    assign w_invuln   = (r_inv_cnt != 8'd0);

    assign bus.enemySel     = r_sel;
    assign bus.killIdx      = r_sel;
    assign bus.invulnerable = w_invuln;

    always_ff @(posedge clk) begin
        if (reset || bus.inGameOverState) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_hit     <= 1'b0;
            r_inv_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                IDLE: begin
                    if (bus.startScan) begin
                        r_hit <= 1'b0;
                        if (w_invuln) r_inv_cnt <= r_inv_cnt - 8'd1;
                    end
                end
                SCAN: begin
                    if (w_hit_slot && !w_invuln) r_hit <= 1'b1;
                    r_sel <= (r_sel == LAST_SLOT) ? '0 : r_sel + 1'b1;
                end
                DONE: begin
                end
                PENDING: begin
                    // A frame tick here only ages the window; the scan for that frame is skipped.
                    if (bus.startScan && w_invuln) r_inv_cnt <= r_inv_cnt - 8'd1;
                    if (bus.inUpdatePositionStateMain) begin
                        r_inv_cnt <= INV_LOAD;
                        r_hit     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state     = r_state;
        bus.enemyKill    = 1'b0;
        bus.updateHealth = 1'b0;
        bus.scanDone     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.startScan) w_next_state = SCAN;
            end
            SCAN: begin
                bus.enemyKill = w_hit_slot;
                if (r_sel == LAST_SLOT) w_next_state = DONE;
            end
            DONE: begin
                bus.scanDone = 1'b1;
                w_next_state = r_hit ? PENDING : IDLE;
            end
            PENDING: begin
                bus.updateHealth = bus.inUpdatePositionStateMain;
                if (bus.inUpdatePositionStateMain) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_collision_damage_gen.sv
// Directed bench for collision_damage_gen: enemy table model, kill/damage scoreboard,
// invulnerability frame model.
module tb_collision_damage_gen;
    localparam int N   = 8;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int INV = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    collision_damage_gen_if #(.NUM_ENEMIES(N), .X_W(XW), .Y_W(YW)) bus ();

    collision_damage_gen #(
        .NUM_ENEMIES(N), .X_W(XW), .Y_W(YW),
        .PLAYER_SIZE(8), .ENEMY_SIZE(4), .INVULN_FRAMES(INV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [XW-1:0] ex [N];
    logic [YW-1:0] ey [N];
    logic          ev [N];
    int px, py;

    always_comb begin
        bus.enemyX     = ex[bus.enemySel];
        bus.enemyY     = ey[bus.enemySel];
        bus.enemyValid = ev[bus.enemySel];
    end

    int n_chk = 0;
    int n_err = 0;
    int m_inv = 0;
    int q_kill [$];
    int q_upd  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_player(input int x, input int y);
        px = x;
        py = y;
        bus.playerX = x[XW-1:0];
        bus.playerY = y[YW-1:0];
    endtask

    task automatic clear_enemies();
        for (int k = 0; k < N; k++) begin
            ex[k] = '0; ey[k] = '0; ev[k] = 1'b0;
        end
    endtask

    task automatic put_enemy(input int k, input int x, input int y);
        ex[k] = x[XW-1:0];
        ey[k] = y[YW-1:0];
        ev[k] = 1'b1;
    endtask

    function automatic bit ovl(input int k);
        int x, y;
        x = int'(ex[k]);
        y = int'(ey[k]);
        return ev[k] && (x < px + 8) && (px < x + 4) && (y < py + 8) && (py < y + 4);
    endfunction

    task automatic scan_slot(input string tag, input int k);
        @(negedge clk);
        check({tag, "/sel"}, 32'(bus.enemySel), k);
        if (q_kill.size() > 0 && q_kill[0] == k) begin
            check({tag, "/kill"}, 32'(bus.enemyKill), 1);
            check({tag, "/killIdx"}, 32'(bus.killIdx), k);
            void'(q_kill.pop_front());
        end else begin
            check({tag, "/nokill"}, 32'(bus.enemyKill), 0);
        end
        tick();
    endtask

    task automatic run_frame(input string tag, input int upd_wait);
        bit exp_hit;
        int pulses, first;
        if (m_inv > 0) m_inv--;
        exp_hit = 0;
        for (int k = 0; k < N; k++)
            if (ovl(k)) begin
                q_kill.push_back(k);
                if (m_inv == 0) exp_hit = 1;
            end
        if (exp_hit) q_upd.push_back(upd_wait);
        bus.startScan = 1'b1;
        tick();
        bus.startScan = 1'b0;
        for (int k = 0; k < N; k++) scan_slot(tag, k);
        @(negedge clk);
        check({tag, "/scanDone"}, 32'(bus.scanDone), 1);
        tick();
        pulses = 0;
        first  = -1;
        for (int i = 0; i < upd_wait + 5; i++) begin
            bus.inUpdatePositionStateMain = (i >= upd_wait);
            @(negedge clk);
            if (bus.updateHealth === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            tick();
        end
        bus.inUpdatePositionStateMain = 1'b0;
        if (q_upd.size() > 0) begin
            check({tag, "/updPulses"}, pulses, 1);
            check({tag, "/updCycle"}, first, q_upd.pop_front());
            m_inv = INV;
        end else begin
            check({tag, "/noUpd"}, pulses, 0);
        end
        @(negedge clk);
        check({tag, "/invuln"}, 32'(bus.invulnerable), (m_inv != 0) ? 1 : 0);
        tick();
    endtask

    task automatic drain(input string tag);
        clear_enemies();
        for (int f = 0; f < INV + 1; f++)
            if (m_inv > 0) run_frame(tag, 0);
    endtask

    task automatic abort_frame(input string tag, input bit use_reset);
        int pulses, dones;
        if (m_inv > 0) m_inv--;
        for (int k = 0; k < 4; k++)
            if (ovl(k)) q_kill.push_back(k);
        bus.startScan = 1'b1;
        tick();
        bus.startScan = 1'b0;
        for (int k = 0; k < 4; k++) scan_slot(tag, k);
        if (use_reset) reset = 1'b1;
        else bus.inGameOverState = 1'b1;
        tick();
        reset = 1'b0;
        bus.inGameOverState = 1'b0;
        @(negedge clk);
        check({tag, "/sel0"}, 32'(bus.enemySel), 0);
        check({tag, "/invuln0"}, 32'(bus.invulnerable), 0);
        pulses = 0;
        dones  = 0;
        bus.inUpdatePositionStateMain = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.updateHealth !== 1'b0) pulses++;
            if (bus.scanDone !== 1'b0) dones++;
            tick();
        end
        bus.inUpdatePositionStateMain = 1'b0;
        check({tag, "/noUpd"}, pulses, 0);
        check({tag, "/noDone"}, dones, 0);
        m_inv = 0;
        q_kill.delete();
    endtask

    initial begin
        reset = 1'b1;
        bus.startScan = 1'b0;
        bus.inUpdatePositionStateMain = 1'b0;
        bus.inGameOverState = 1'b0;
        set_player(50, 50);
        clear_enemies();
        tick();
        tick();
        @(negedge clk);
        check("rst/updateHealth", 32'(bus.updateHealth), 0);
        check("rst/enemyKill", 32'(bus.enemyKill), 0);
        check("rst/scanDone", 32'(bus.scanDone), 0);
        check("rst/invulnerable", 32'(bus.invulnerable), 0);
        check("rst/enemySel", 32'(bus.enemySel), 0);
        check("rst/killIdx", 32'(bus.killIdx), 0);
        reset = 1'b0;
        tick();

        // Single hit: slot 3 overlaps, update-position state from t+12.
        put_enemy(3, 55, 52);
        run_frame("single", 2);

        // Edge adjacency on every side, plus one just-inside corner.
        clear_enemies();
        put_enemy(0, 58, 50);
        put_enemy(1, 50, 58);
        put_enemy(2, 46, 50);
        put_enemy(4, 50, 46);
        put_enemy(3, 57, 57);
        run_frame("edge", 0);

        // Coordinates near the maximum must not wrap.
        clear_enemies();
        set_player(250, 50);
        put_enemy(0, 2, 50);
        put_enemy(5, 253, 52);
        run_frame("wrapx", 1);
        clear_enemies();
        set_player(100, 122);
        put_enemy(2, 102, 125);
        put_enemy(6, 100, 2);
        run_frame("wrapy", 1);

        // Hit followed by repeated overlaps through the invulnerability window.
        drain("drain1");
        set_player(50, 50);
        put_enemy(4, 52, 52);
        for (int f = 0; f < 5; f++) run_frame("invwin", 1);

        // Several overlaps in one frame give one damage pulse.
        drain("drain2");
        set_player(50, 50);
        put_enemy(1, 50, 50);
        put_enemy(2, 54, 56);
        put_enemy(7, 47, 47);
        put_enemy(5, 70, 50);
        run_frame("multi", 0);

        // Long wait for the update-position state.
        drain("drain3");
        put_enemy(0, 51, 51);
        run_frame("pending", 20);

        // Aborts after a hit has been flagged.
        drain("drain4");
        put_enemy(1, 52, 50);
        abort_frame("abortGO", 1'b0);
        abort_frame("abortRst", 1'b1);

        // Abort while the invulnerability window is open clears it.
        run_frame("hitAgain", 0);
        abort_frame("abortInv", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
